// File: rtl/combo_lock_fsm.sv
// -----------------------------------------------------------------------------
// combo_lock_fsm
//   Combination-lock controller for the lock board. Takes the raw keypad link
//   (4-bit key code plus active-low valid strobe, both asynchronous), cleans each
//   press into a single key event, and runs the LOCKED/OPEN/PROG/ALARM state
//   machine that drives the lock LEDs and HEX displays.
//
//   Key interface: key_validn is held low for the whole press and key_code is
//   stable while it is low. There is no backpressure. Every falling edge of
//   key_validn becomes exactly one key_evt pulse, whatever the lock state is.
//
// Ports
//   clk           in   system clock (50 MHz)
//   rst_n         in   asynchronous active-low reset
//   key_code      in   key from the keypad: 0-9 digits, A-D, E='#', F='*'
//   key_validn    in   active-low key valid, low for the whole press
//   key_evt       out  one-cycle pulse per detected press
//   state         out  0=LOCKED 1=OPEN 2=PROG 3=ALARM
//   unlocked      out  high in OPEN or PROG
//   alarm         out  high in ALARM
//   entry_digits  out  digit buffer, newest digit in [3:0]
//   entry_cnt     out  digits held, saturates at CODE_LEN
//   fail_cnt      out  consecutive failed attempts, saturates at MAX_FAILS
//   prog_err      out  one-cycle pulse: '#' in PROG with a short entry
// -----------------------------------------------------------------------------
module combo_lock_fsm #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    LOCKOUT_CYCLES = 150000000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [3:0]                         key_code,
    input  logic                               key_validn,
    output logic                               key_evt,
    output logic [1:0]                         state,
    output logic                               unlocked,
    output logic                               alarm,
    output logic [4*CODE_LEN-1:0]              entry_digits,
    output logic [$clog2(CODE_LEN+1)-1:0]      entry_cnt,
    output logic [2:0]                         fail_cnt,
    output logic                               prog_err
);

    localparam int DW = 4 * CODE_LEN;
    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_FULL   = CW'(CODE_LEN);
    localparam logic [2:0]    FAIL_LIMIT = 3'(MAX_FAILS);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_STAR = 4'hF;

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_PROG   = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Reset: asserts immediately, releases on a clock edge so no flop sees
    // a release too close to the edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_pipe;
    logic       rst_core_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_core_n = rst_pipe[1];

    // ------------------------------------------------------------------
    // Input capture: two-flop synchronisers, then a rising-edge detector on
    // the active-high valid. The event and the key value are registered
    // together, so key_q is stable for the whole key_evt cycle.
    // ------------------------------------------------------------------
    logic       validn_meta, validn_s;
    logic [3:0] code_meta, code_s;
    logic       v, v_d;
    logic       evt_q;
    logic [3:0] key_q;

    assign v = ~validn_s;

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            validn_meta <= 1'b1;
            validn_s    <= 1'b1;
            code_meta   <= 4'h0;
            code_s      <= 4'h0;
            v_d         <= 1'b0;
            evt_q       <= 1'b0;
            key_q       <= 4'h0;
        end else begin
            validn_meta <= key_validn;
            validn_s    <= validn_meta;
            code_meta   <= key_code;
            code_s      <= code_meta;
            v_d         <= v;
            evt_q       <= v & ~v_d;
            if (v & ~v_d) begin
                key_q <= code_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------
    state_t        state_q, state_nx;
    logic [DW-1:0] buf_q, buf_nx;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic          ovf_q, ovf_nx;
    logic [2:0]    fail_q, fail_nx;
    logic [DW-1:0] combo_q, combo_nx;
    logic [TW-1:0] timer_q, timer_nx;
    logic          perr_q, perr_nx;

    logic          do_push, do_clear;
    logic          key_is_digit;
    logic          code_match;
    logic [2:0]    fail_inc;
    logic [DW-1:0] buf_push;

    assign key_is_digit = (key_q <= 4'd9);
    // Overflowed entries never match, even if the last digits are right.
    assign code_match   = (cnt_q == CNT_FULL) && !ovf_q && (buf_q == combo_q);
    assign fail_inc     = (fail_q >= FAIL_LIMIT) ? fail_q : fail_q + 3'd1;
    // Shift left one nibble; the oldest digit falls off the top.
    assign buf_push     = DW'({buf_q, key_q});

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q <= ST_LOCKED;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            fail_q  <= 3'd0;
            combo_q <= DEFAULT_CODE;
            timer_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            buf_q   <= buf_nx;
            cnt_q   <= cnt_nx;
            ovf_q   <= ovf_nx;
            fail_q  <= fail_nx;
            combo_q <= combo_nx;
            timer_q <= timer_nx;
            perr_q  <= perr_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        buf_nx   = buf_q;
        cnt_nx   = cnt_q;
        ovf_nx   = ovf_q;
        fail_nx  = fail_q;
        combo_nx = combo_q;
        timer_nx = timer_q;
        perr_nx  = 1'b0;
        do_push  = 1'b0;
        do_clear = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                if (evt_q) begin
                    if (key_is_digit) begin
                        do_push = 1'b1;
                    end else if (key_q == KEY_STAR) begin
                        do_clear = 1'b1;
                    end else if (key_q == KEY_HASH) begin
                        do_clear = 1'b1;
                        if (code_match) begin
                            state_nx = ST_OPEN;
                            fail_nx  = 3'd0;
                        end else begin
                            fail_nx = fail_inc;
                            if (fail_inc == FAIL_LIMIT) begin
                                state_nx = ST_ALARM;
                                timer_nx = TIMER_LOAD;
                            end
                        end
                    end
                end
            end

            ST_OPEN: begin
                if (evt_q) begin
                    if (key_q == KEY_STAR) begin
                        state_nx = ST_LOCKED;
                        do_clear = 1'b1;
                    end else if (key_q == KEY_A) begin
                        state_nx = ST_PROG;
                        do_clear = 1'b1;
                    end
                end
            end

            ST_PROG: begin
                if (evt_q) begin
                    if (key_is_digit) begin
                        do_push = 1'b1;
                    end else if (key_q == KEY_HASH) begin
                        do_clear = 1'b1;
                        if (cnt_q == CNT_FULL) begin
                            // Overflow is fine here: the last CODE_LEN digits win.
                            combo_nx = buf_q;
                            state_nx = ST_OPEN;
                        end else begin
                            perr_nx = 1'b1;
                        end
                    end else if (key_q == KEY_STAR) begin
                        state_nx = ST_OPEN;
                        do_clear = 1'b1;
                    end
                end
            end

            ST_ALARM: begin
                // Key events are dropped for the whole lockout, including
                // one landing on the expiry cycle.
                if (timer_q == '0) begin
                    state_nx = ST_LOCKED;
                    fail_nx  = 3'd0;
                    do_clear = 1'b1;
                end else begin
                    timer_nx = timer_q - TW'(1);
                end
            end

            default: begin
                state_nx = ST_LOCKED;
                do_clear = 1'b1;
            end
        endcase

        if (do_clear) begin
            buf_nx = '0;
            cnt_nx = '0;
            ovf_nx = 1'b0;
        end else if (do_push) begin
            buf_nx = buf_push;
            if (cnt_q < CNT_FULL) begin
                cnt_nx = cnt_q + CW'(1);
            end else begin
                ovf_nx = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign key_evt      = evt_q;
    assign state        = state_q;
    assign unlocked     = (state_q == ST_OPEN) || (state_q == ST_PROG);
    assign alarm        = (state_q == ST_ALARM);
    assign entry_digits = buf_q;
    assign entry_cnt    = cnt_q;
    assign fail_cnt     = fail_q;
    assign prog_err     = perr_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// -----------------------------------------------------------------------------
// tb_combo_lock_fsm
//   Self-checking bench for combo_lock_fsm with a short lockout. A per-cycle
//   monitor compares every output against a key-level reference model (digit
//   queue, combination array, alarm end cycle). A press table and directed
//   sequences cover latency, key hold, overflow, alarm timing, programming
//   and mid-entry reset; a random phase follows.
// -----------------------------------------------------------------------------
module tb_combo_lock_fsm;

  localparam int LOCK = 20;
  localparam logic [3:0] K_A    = 4'hA;
  localparam logic [3:0] K_HASH = 4'hE;
  localparam logic [3:0] K_STAR = 4'hF;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_validn = 1'b1;
  logic        key_evt;
  logic [1:0]  state;
  logic        unlocked;
  logic        alarm;
  logic [15:0] entry_digits;
  logic [2:0]  entry_cnt;
  logic [2:0]  fail_cnt;
  logic        prog_err;

  always #5 clk = ~clk;

  combo_lock_fsm #(
    .CODE_LEN       (4),
    .DEFAULT_CODE   (16'h1234),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_code     (key_code),
    .key_validn   (key_validn),
    .key_evt      (key_evt),
    .state        (state),
    .unlocked     (unlocked),
    .alarm        (alarm),
    .entry_digits (entry_digits),
    .entry_cnt    (entry_cnt),
    .fail_cnt     (fail_cnt),
    .prog_err     (prog_err)
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int evt_cnt  = 0;
  int press_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The lock is described per key: a queue of entered digits since the last
  // clear, the combination as CODE_LEN digits, and the cycle at which the
  // lockout ends.
  int         m_state;
  logic [3:0] m_dig[$];
  logic [3:0] m_combo[4];
  int         m_fail;
  int         m_alarm_end;
  int         m_perr_cyc;

  function automatic void model_reset();
    m_state = 0;
    m_dig.delete();
    m_combo[0] = 4'd1; m_combo[1] = 4'd2; m_combo[2] = 4'd3; m_combo[3] = 4'd4;
    m_fail = 0;
    m_alarm_end = 0;
    m_perr_cyc = -1;
  endfunction

  function automatic bit model_match();
    int n = m_dig.size();
    if (n != 4) return 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_dig[i] != m_combo[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] model_buf();
    logic [15:0] b = 16'h0;
    int n = m_dig.size();
    for (int i = 0; i < 4 && i < n; i++) b[4*i +: 4] = m_dig[n-1-i];
    return b;
  endfunction

  function automatic void model_settle(input int c);
    if (m_state == 3 && c >= m_alarm_end) begin
      m_state = 0;
      m_fail = 0;
      m_dig.delete();
    end
  endfunction

  // Apply one key event taken on clock edge number e.
  function automatic void model_apply(input logic [3:0] k, input int e);
    int n;
    if (m_state == 3 && e <= m_alarm_end) return;
    model_settle(e);
    n = m_dig.size();
    case (m_state)
      0: begin
        if (k <= 4'd9) m_dig.push_back(k);
        else if (k == K_STAR) m_dig.delete();
        else if (k == K_HASH) begin
          if (model_match()) begin
            m_state = 1;
            m_fail = 0;
          end else begin
            if (m_fail < 3) m_fail++;
            if (m_fail == 3) begin
              m_state = 3;
              m_alarm_end = e + LOCK;
            end
          end
          m_dig.delete();
        end
      end
      1: begin
        if (k == K_STAR) begin m_state = 0; m_dig.delete(); end
        else if (k == K_A) begin m_state = 2; m_dig.delete(); end
      end
      2: begin
        if (k <= 4'd9) m_dig.push_back(k);
        else if (k == K_HASH) begin
          if (n >= 4) begin
            for (int i = 0; i < 4; i++) m_combo[i] = m_dig[n-4+i];
            m_state = 1;
          end else begin
            m_perr_cyc = e;
          end
          m_dig.delete();
        end else if (k == K_STAR) begin
          m_state = 1;
          m_dig.delete();
        end
      end
      default: ;
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  bit         mon_en = 1'b0;
  bit         pend = 1'b0;
  logic [3:0] pend_key;
  logic [3:0] drv_key = 4'h0;

  always @(negedge clk) begin
    if (key_evt === 1'b1) evt_cnt++;
    if (mon_en) begin
      if (pend) begin
        model_apply(pend_key, cyc);
        pend = 1'b0;
      end
      model_settle(cyc);
      check("mon_state",    32'(state),        32'(m_state));
      check("mon_unlocked", 32'(unlocked),     32'(m_state == 1 || m_state == 2));
      check("mon_alarm",    32'(alarm),        32'(m_state == 3));
      check("mon_digits",   32'(entry_digits), 32'(model_buf()));
      check("mon_cnt",      32'(entry_cnt),    32'((m_dig.size() > 4) ? 4 : m_dig.size()));
      check("mon_fail",     32'(fail_cnt),     32'(m_fail));
      check("mon_prog_err", 32'(prog_err),     32'(m_perr_cyc == cyc));
      if (key_evt === 1'b1) begin
        pend = 1'b1;
        pend_key = drv_key;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Press a key: validn low for 'hold' cycles (>=3), then high for 'gap'
  // cycles. key_evt must appear exactly 3 clocks after the falling edge.
  task automatic press(input logic [3:0] k, input int hold, input int gap);
    @(negedge clk);
    key_code = k;
    key_validn = 1'b0;
    drv_key = k;
    press_cnt++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("evt_latency", 32'(key_evt), 32'(i == 3));
    end
    for (int i = 3; i < hold; i++) @(negedge clk);
    key_validn = 1'b1;
    key_code = 4'($urandom_range(0, 15));
    for (int i = 0; i < gap; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    pend = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    key_validn = 1'b1;
    model_reset();
    #1;
    check("rst_state",    32'(state),        32'd0);
    check("rst_unlocked", 32'(unlocked),     32'd0);
    check("rst_alarm",    32'(alarm),        32'd0);
    check("rst_digits",   32'(entry_digits), 32'd0);
    check("rst_cnt",      32'(entry_cnt),    32'd0);
    check("rst_fail",     32'(fail_cnt),     32'd0);
    check("rst_key_evt",  32'(key_evt),      32'd0);
    check("rst_prog_err", 32'(prog_err),     32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic press_seq4(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[4*i +: 4], 3, 3);
  endtask

  // ---------------- press table ----------------
  typedef struct {
    logic [3:0] key;
    logic [1:0] st;
    logic [2:0] fail;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic [3:0] k, input logic [1:0] s,
                               input logic [2:0] f, input logic [2:0] c);
    vec_t v;
    v.key = k; v.st = s; v.fail = f; v.cnt = c;
    vecs.push_back(v);
  endfunction

  // ---------------- test ----------------
  initial begin
    int e0;
    int r;
    logic [3:0] k;

    // open with default code, lock, overflow failure, reopen
    addv(4'd1, 0, 0, 1); addv(4'd2, 0, 0, 2); addv(4'd3, 0, 0, 3); addv(4'd4, 0, 0, 4);
    addv(K_HASH, 1, 0, 0); addv(K_STAR, 0, 0, 0);
    addv(4'd1, 0, 0, 1); addv(4'd2, 0, 0, 2); addv(4'd3, 0, 0, 3); addv(4'd4, 0, 0, 4);
    addv(4'd5, 0, 0, 4); addv(K_HASH, 0, 1, 0);
    addv(4'd1, 0, 1, 1); addv(4'd2, 0, 1, 2); addv(4'd3, 0, 1, 3); addv(4'd4, 0, 1, 4);
    addv(K_HASH, 1, 0, 0);
    // program 9876, back to open, lock, reopen with new code
    addv(K_A, 2, 0, 0); addv(4'd9, 2, 0, 1); addv(4'd8, 2, 0, 2); addv(4'd7, 2, 0, 3);
    addv(4'd6, 2, 0, 4); addv(K_HASH, 1, 0, 0); addv(K_STAR, 0, 0, 0);
    addv(4'd9, 0, 0, 1); addv(4'd8, 0, 0, 2); addv(4'd7, 0, 0, 3); addv(4'd6, 0, 0, 4);
    addv(K_HASH, 1, 0, 0); addv(4'd5, 1, 0, 0); addv(K_STAR, 0, 0, 0);
    // old code now fails; B is ignored
    addv(4'd1, 0, 0, 1); addv(4'd2, 0, 0, 2); addv(4'd3, 0, 0, 3); addv(4'd4, 0, 0, 4);
    addv(K_HASH, 0, 1, 0); addv(4'hB, 0, 1, 0);

    model_reset();
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      press(vecs[i].key, 3 + (i % 3), 3);
      check("tbl_state", 32'(state),     32'(vecs[i].st));
      check("tbl_fail",  32'(fail_cnt),  32'(vecs[i].fail));
      check("tbl_cnt",   32'(entry_cnt), 32'(vecs[i].cnt));
    end

    // long hold -> exactly one event
    do_reset();
    e0 = evt_cnt;
    press(4'd5, 1000, 4);
    check("hold_evts",   32'(evt_cnt - e0), 32'd1);
    check("hold_digits", 32'(entry_digits), 32'h0005);
    check("hold_cnt",    32'(entry_cnt),    32'd1);

    // three failures -> alarm for exactly LOCK cycles
    do_reset();
    press(K_HASH, 3, 3);
    press(K_HASH, 3, 3);
    check("fail_two", 32'(fail_cnt), 32'd2);
    press(K_HASH, 3, 0);
    for (int i = 1; i <= LOCK + 2; i++) begin
      @(negedge clk);
      check("alarm_len", 32'(alarm), 32'(i <= LOCK));
    end
    check("alarm_exit_state", 32'(state),    32'd0);
    check("alarm_exit_fail",  32'(fail_cnt), 32'd0);

    // keys during alarm dropped, including one on the expiry cycle
    press(K_HASH, 3, 3);
    press(K_HASH, 3, 3);
    press(K_HASH, 3, 0);
    press(4'd7, 3, 3);
    repeat (9) @(negedge clk);
    press(4'd5, 3, 3);
    check("expiry_state", 32'(state),     32'd0);
    check("expiry_cnt",   32'(entry_cnt), 32'd0);
    press(4'd3, 3, 3);
    check("post_alarm_digits", 32'(entry_digits), 32'h0003);

    // program 5566, short entry error, reset mid-entry restores default
    do_reset();
    press_seq4(16'h1234);
    press(K_HASH, 3, 3);
    press(K_A, 3, 3);
    press_seq4(16'h5566);
    press(K_HASH, 3, 3);
    check("prog_open", 32'(state), 32'd1);
    press(K_A, 3, 3);
    press(4'd9, 3, 3);
    press(4'd8, 3, 3);
    press(K_HASH, 3, 0);
    @(negedge clk);
    check("perr_pulse", 32'(prog_err), 32'd1);
    check("perr_state", 32'(state),    32'd2);
    check("perr_cnt",   32'(entry_cnt), 32'd0);
    @(negedge clk);
    check("perr_end",   32'(prog_err), 32'd0);
    press(4'd7, 3, 3);
    check("mid_cnt", 32'(entry_cnt), 32'd1);
    do_reset();
    press_seq4(16'h5566);
    press(K_HASH, 3, 3);
    check("lost_code_state", 32'(state),    32'd0);
    check("lost_code_fail",  32'(fail_cnt), 32'd1);
    press_seq4(16'h1234);
    press(K_HASH, 3, 3);
    check("default_code_open", 32'(state), 32'd1);

    // random phase
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else if (r < 14) begin
        for (int i = 0; i < 4; i++)
          press(m_combo[i], $urandom_range(3, 6), $urandom_range(3, 5));
        press(K_HASH, $urandom_range(3, 6), $urandom_range(3, 5));
      end else begin
        r = $urandom_range(0, 99);
        if (r < 55)      k = 4'($urandom_range(0, 9));
        else if (r < 70) k = K_HASH;
        else if (r < 80) k = K_STAR;
        else if (r < 92) k = K_A;
        else             k = 4'($urandom_range(11, 13));
        press(k, $urandom_range(3, 6), $urandom_range(3, 5));
      end
    end

    repeat (LOCK + 5) @(negedge clk);
    mon_en = 1'b0;
    check("evt_total", 32'(evt_cnt), 32'(press_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
